// File: rtl/rv32ima_pkg.sv
// Shared RV32IMA types: machine word, register tag, and the multiply/divide
// operation and state encodings used by the execute-stage muldiv unit.
package rv32ima_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  reg_t;

   // Encodings follow the RV32M funct3 field
   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } mdop_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   function automatic logic md_is_div(input mdop_t op);
      return op inside {DIV, DIVU, REM, REMU};
   endfunction

   function automatic logic md_is_rem(input mdop_t op);
      return op inside {REM, REMU};
   endfunction

   function automatic logic md_rs1_signed(input mdop_t op);
      return op inside {MUL, MULH, MULHSU, DIV, REM};
   endfunction

   function automatic logic md_rs2_signed(input mdop_t op);
      return op inside {MUL, MULH, DIV, REM};
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One compute iteration of the muldiv unit: BITS_PER_CYCLE rounds of either
// shift-add multiply or restoring divide on unsigned magnitudes.
module muldiv_step
   import rv32ima_pkg::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] part_i,
   input  logic [WIDTH-1:0] operand_i,
   input  logic             is_div_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] part_o
);

   // acc holds the product high half / partial remainder; part holds the
   // multiplier being shifted out / quotient being shifted in.
   always_comb begin : step
      logic [WIDTH-1:0] hi;
      logic [WIDTH-1:0] lo;
      logic [WIDTH:0]   t;
      hi = acc_i;
      lo = part_i;
      t  = '0;
      for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
         if (is_div_i) begin
            t  = {hi, lo[WIDTH-1]};
            lo = {lo[WIDTH-2:0], 1'b0};
            if (t >= {1'b0, operand_i}) begin
               t     = t - {1'b0, operand_i};
               lo[0] = 1'b1;
            end
            hi = t[WIDTH-1:0];
         end else begin
            t  = {1'b0, hi} + (lo[0] ? {1'b0, operand_i} : '0);
            hi = t[WIDTH:1];
            lo = {t[0], lo[WIDTH-1:1]};
         end
      end
      acc_o  = hi;
      part_o = lo;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes on both
// sides; one operation in flight, fixed latency for every op.
module muldiv_unit
   import rv32ima_pkg::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             in_valid,
   output logic             in_ready,
   input  mdop_t            op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  reg_t             rd_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output reg_t             rd_out
);

   localparam int unsigned STEPS    = WIDTH / BITS_PER_CYCLE;
   localparam int unsigned CNT_W    = $clog2(STEPS + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   md_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mdop_t            op_q, op_d;
   reg_t             rd_q, rd_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic             spec_q, spec_d;
   logic [WIDTH-1:0] spec_res_q, spec_res_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH-1:0]   step_acc, step_part;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   quot_s, rem_s, final_res;

   muldiv_step #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .acc_i     (acc_q),
      .part_i    (part_q),
      .operand_i (opnd_q),
      .is_div_i  (md_is_div(op_q)),
      .acc_o     (step_acc),
      .part_o    (step_part)
   );

   always_comb begin
      a_neg = md_rs1_signed(op) & in1[WIDTH-1];
      b_neg = md_rs2_signed(op) & in2[WIDTH-1];
      a_mag = a_neg ? -in1 : in1;
      b_mag = b_neg ? -in2 : in2;

      // Sign fix-up is applied to the final step output so the result
      // register is written on the same edge that enters DONE.
      prod   = {step_acc, step_part};
      prod_s = negq_q ? -prod : prod;
      quot_s = negq_q ? -step_part : step_part;
      rem_s  = negr_q ? -step_acc : step_acc;

      final_res = rem_s;
      case (op_q)
         MUL:                 final_res = prod_s[WIDTH-1:0];
         MULH, MULHSU, MULHU: final_res = prod_s[2*WIDTH-1:WIDTH];
         DIV, DIVU:           final_res = quot_s;
         default:             final_res = rem_s;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      rd_d       = rd_q;
      opnd_d     = opnd_q;
      acc_d      = acc_q;
      part_d     = part_q;
      negq_d     = negq_q;
      negr_d     = negr_q;
      spec_d     = spec_q;
      spec_res_d = spec_res_q;
      result_d   = result_q;

      case (state_q)
         MD_IDLE: begin
            if (in_valid && !flush) begin
               op_d       = op;
               rd_d       = rd_in;
               acc_d      = '0;
               negq_d     = a_neg ^ b_neg;
               negr_d     = a_neg;
               spec_d     = md_is_div(op) && (in2 == '0);
               spec_res_d = md_is_rem(op) ? in1 : '1;
               cnt_d      = CNT_LOAD;
               if (md_is_div(op)) begin
                  opnd_d = b_mag;
                  part_d = a_mag;
               end else begin
                  opnd_d = a_mag;
                  part_d = b_mag;
               end
               state_d = MD_BUSY;
            end
         end
         MD_BUSY: begin
            acc_d  = step_acc;
            part_d = step_part;
            cnt_d  = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               result_d = spec_q ? spec_res_q : final_res;
               state_d  = MD_DONE;
            end
         end
         MD_DONE: begin
            if (out_ready) state_d = MD_IDLE;
         end
         default: state_d = MD_IDLE;
      endcase

      if (flush) state_d = MD_IDLE;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= MD_IDLE;
         cnt_q      <= '0;
         op_q       <= MUL;
         rd_q       <= '0;
         opnd_q     <= '0;
         acc_q      <= '0;
         part_q     <= '0;
         negq_q     <= 1'b0;
         negr_q     <= 1'b0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         rd_q       <= rd_d;
         opnd_q     <= opnd_d;
         acc_q      <= acc_d;
         part_q     <= part_d;
         negq_q     <= negq_d;
         negr_q     <= negr_d;
         spec_q     <= spec_d;
         spec_res_q <= spec_res_d;
         result_q   <= result_d;
      end
   end

   assign in_ready  = (state_q == MD_IDLE) && !flush;
   assign out_valid = (state_q == MD_DONE) && !flush;
   assign result    = result_q;
   assign rd_out    = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: RV32M reference arithmetic on 64-bit
// integers, a result scoreboard, and directed handshake/flush/reset scenarios.
module tb_muldiv_unit;
   import rv32ima_pkg::*;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned BPC   = 1;
   localparam int unsigned STEPS = WIDTH / BPC;

   logic  clk, nrst, in_valid, in_ready, flush, out_valid, out_ready;
   mdop_t op;
   word_t in1, in2, result;
   reg_t  rd_in, rd_out;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      word_t res;
      reg_t  rd;
      int    acc;
      bit    seen;
   } exp_t;
   exp_t exp_q[$];

   muldiv_unit #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BPC)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .in1       (in1),
      .in2       (in2),
      .rd_in     (rd_in),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .rd_out    (rd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // Reference RV32M semantics computed with wide integer arithmetic
   function automatic word_t model(input mdop_t o, input word_t a, input word_t b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = longint'({32'b0, a});
      longint ub = longint'({32'b0, b});
      longint p;
      case (o)
         MUL:    begin p = sa * sb; return p[31:0];  end
         MULH:   begin p = sa * sb; return p[63:32]; end
         MULHSU: begin p = sa * ub; return p[63:32]; end
         MULHU:  begin p = ua * ub; return p[63:32]; end
         DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb;
            return p[31:0];
         end
         REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb;
            return p[31:0];
         end
         DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic issue(input mdop_t o, input word_t a, input word_t b, input reg_t r,
                        output int waits);
      waits    = 0;
      op       = o;
      in1      = a;
      in2      = b;
      rd_in    = r;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back('{model(o, a, b), r, cyc + 1, 1'b0});
            break;
         end
         waits++;
         if (waits > 100) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            break;
         end
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("result_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      #1;
   endtask

   task automatic wait_out_valid();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 100);
      if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   function automatic word_t pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // Scoreboard: every cycle the unit presents a result, it must match
   always @(negedge clk) begin
      if (nrst && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out_valid: got out_valid=1 result=%h expected no result", result);
         end else begin
            chk("result", result, exp_q[0].res);
            chk("rd_out", 32'(rd_out), 32'(exp_q[0].rd));
            if (!exp_q[0].seen) begin
               chk("latency", 32'(cyc - exp_q[0].acc + 1), 32'(STEPS + 1));
               exp_q[0].seen = 1'b1;
            end
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   typedef struct {
      mdop_t o;
      word_t a;
      word_t b;
      word_t lit;
   } vec_t;

   initial begin
      vec_t  vecs[$];
      word_t r0;
      int    w;

      nrst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      op = MUL; in1 = '0; in2 = '0; rd_in = '0;
      #3 nrst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_result", result, 32'h0);
      chk("reset_rd_out", 32'(rd_out), 32'd0);
      tick();
      nrst = 1'b1;
      tick();

      vecs.push_back('{MUL,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
      vecs.push_back('{MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
      vecs.push_back('{DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
      vecs.push_back('{REM,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
      vecs.push_back('{DIVU,  32'd100,        32'd7,         32'd14});
      vecs.push_back('{REMU,  32'd100,        32'd7,         32'd2});
      vecs.push_back('{DIV,   32'd5,          32'd0,         32'hFFFF_FFFF});
      vecs.push_back('{REM,   32'd5,          32'd0,         32'd5});
      vecs.push_back('{DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
      vecs.push_back('{REM,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0});
      vecs.push_back('{MULH,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
      vecs.push_back('{MULHSU,32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF});
      foreach (vecs[i]) begin
         chk("model_pin", model(vecs[i].o, vecs[i].a, vecs[i].b), vecs[i].lit);
         issue(vecs[i].o, vecs[i].a, vecs[i].b, reg_t'(i + 3), w);
         wait_done();
      end

      // Result held while writeback stalls, then immediate back-to-back accept
      issue(DIVU, 32'd1000, 32'd3, 5'd9, w);
      out_ready = 1'b0;
      wait_out_valid();
      r0 = result;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         chk("hold_result", result, r0);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_out_valid", 32'(out_valid), 32'd1);
      end
      tick();
      out_ready = 1'b1;
      issue(MUL, 32'd12345, 32'd678, 5'd10, w);
      chk("b2b_accept_wait", 32'(w), 32'd1);
      wait_done();

      // Flush during BUSY cycle 12
      issue(DIV, 32'd999, 32'd7, 5'd11, w);
      repeat (10) tick();
      flush = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("flush_in_ready_low", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_busy_idle", 32'(in_ready), 32'd1);
      chk("flush_busy_no_valid", 32'(out_valid), 32'd0);
      idle(40);

      // Flush while a result is held
      issue(REMU, 32'd77, 32'd5, 5'd12, w);
      out_ready = 1'b0;
      wait_out_valid();
      tick();
      flush = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("flush_done_gate", 32'(out_valid), 32'd0);
      tick();
      flush = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("flush_done_valid", 32'(out_valid), 32'd0);
      chk("flush_done_idle", 32'(in_ready), 32'd1);
      idle(40);

      // Flush together with a request in IDLE blocks the accept
      tick();
      op = MUL; in1 = 32'd3; in2 = 32'd4; rd_in = 5'd13;
      in_valid = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_accept_ready", 32'(in_ready), 32'd0);
      tick();
      in_valid = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_accept_idle", 32'(in_ready), 32'd1);
      idle(40);

      // Asynchronous reset during BUSY cycle 10
      issue(MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd14, w);
      repeat (8) tick();
      #2 nrst = 1'b0;
      #1;
      chk("rst_busy_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy_result", result, 32'h0);
      exp_q.delete();
      tick();
      tick();
      nrst = 1'b1;
      idle(40);

      // Randomized operations against the reference model
      for (int i = 0; i < 200; i++) begin
         issue(mdop_t'($urandom_range(0, 7)), pick(), pick(), reg_t'($urandom_range(0, 31)), w);
         if ($urandom_range(0, 3) == 0) begin
            out_ready = 1'b0;
            repeat ($urandom_range(34, 40)) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         wait_done();
      end

      idle(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
